bus_dev_fifo: RTL and testbench

Per-device endpoint that sits directly on one port of the bus generator/arbiter. A transmit FIFO holds device packets and presents them to the bus through pndng/D_pop/pop. A receive FIFO captures packets the bus delivers through push/D_push and hands them to the device. The bench instantiates one per driver (drvrs copies); status counters expose overflow, underflow and misrouted deliveries.

---
 rtl/bus_dev_pkg.sv | 12 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/bus_dev_fifo.sv | 74 +++++++
 tb/tb_bus_dev_fifo.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/bus_dev_pkg.sv
// Shared constants and helpers for the bus device endpoint.
package bus_dev_pkg;
    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;
    localparam int MAX_PKT_W = 256;

    // Destination ID sits in the top ID_W bits of a pkt_w-wide packet.
    function automatic logic [ID_W-1:0] dest_of(input logic [MAX_PKT_W-1:0] pkt,
                                                input int pkt_w);
        return pkt[pkt_w-1 -: ID_W];
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy and per-cycle accept/reject flags.
module sync_fifo #(
    parameter int pckg_sz = 32,
    parameter int depth   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr,
    input  logic [pckg_sz-1:0]         wr_data,
    input  logic                       rd,
    output logic [pckg_sz-1:0]         rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(depth):0]     cnt,
    output logic                       wr_ok,
    output logic                       wr_drop,
    output logic                       rd_ok,
    output logic                       rd_unf
);
    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(depth);

    logic [pckg_sz-1:0] mem [depth];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign rd_ok   = rd && !empty;
    assign rd_unf  = rd && empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign wr_ok   = wr && (!full || rd_ok);
    assign wr_drop = wr && !wr_ok;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/bus_dev_fifo.sv
// Bus device endpoint: TX FIFO toward the bus, RX FIFO from the bus, and
// saturating status counters for drops, underflows and misrouted deliveries.
module bus_dev_fifo
    import bus_dev_pkg::*;
#(
    parameter int             pckg_sz   = 32,
    parameter int             depth     = 16,
    parameter logic [ID_W-1:0] id       = 8'h00,
    parameter logic [ID_W-1:0] broadcast = BROADCAST_ID,
    parameter int             cnt_w     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dev_wr,
    input  logic [pckg_sz-1:0]     dev_wr_data,
    output logic                   dev_tx_full,
    output logic                   pndng,
    output logic [pckg_sz-1:0]     D_pop,
    input  logic                   pop,
    input  logic                   push,
    input  logic [pckg_sz-1:0]     D_push,
    output logic                   dev_rx_valid,
    output logic [pckg_sz-1:0]     dev_rx_data,
    input  logic                   dev_rd,
    output logic [$clog2(depth):0] tx_cnt,
    output logic [$clog2(depth):0] rx_cnt,
    output logic [cnt_w-1:0]       tx_ovf_cnt,
    output logic [cnt_w-1:0]       rx_ovf_cnt,
    output logic [cnt_w-1:0]       pop_unf_cnt,
    output logic [cnt_w-1:0]       misroute_cnt
);
    logic tx_empty, tx_wr_ok, tx_wr_drop, tx_rd_ok, tx_rd_unf;
    logic rx_full, rx_empty, rx_wr_ok, rx_wr_drop, rx_rd_ok, rx_rd_unf;
    logic [ID_W-1:0] dest;
    logic misroute;

    sync_fifo #(.pckg_sz(pckg_sz), .depth(depth)) u_tx (
        .clk(clk), .reset(reset),
        .wr(dev_wr), .wr_data(dev_wr_data),
        .rd(pop), .rd_data(D_pop),
        .full(dev_tx_full), .empty(tx_empty), .cnt(tx_cnt),
        .wr_ok(tx_wr_ok), .wr_drop(tx_wr_drop),
        .rd_ok(tx_rd_ok), .rd_unf(tx_rd_unf)
    );

    sync_fifo #(.pckg_sz(pckg_sz), .depth(depth)) u_rx (
        .clk(clk), .reset(reset),
        .wr(push), .wr_data(D_push),
        .rd(dev_rd), .rd_data(dev_rx_data),
        .full(rx_full), .empty(rx_empty), .cnt(rx_cnt),
        .wr_ok(rx_wr_ok), .wr_drop(rx_wr_drop),
        .rd_ok(rx_rd_ok), .rd_unf(rx_rd_unf)
    );

    assign pndng        = !tx_empty;
    assign dev_rx_valid = !rx_empty;
    assign dest         = dest_of(MAX_PKT_W'(D_push), pckg_sz);
    // Misrouted packets are still stored; only the count flags them.
    assign misroute     = rx_wr_ok && (dest != id) && (dest != broadcast);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_ovf_cnt   <= '0;
            rx_ovf_cnt   <= '0;
            pop_unf_cnt  <= '0;
            misroute_cnt <= '0;
        end else begin
            if (tx_wr_drop && tx_ovf_cnt   != '1) tx_ovf_cnt   <= tx_ovf_cnt   + 1'b1;
            if (rx_wr_drop && rx_ovf_cnt   != '1) rx_ovf_cnt   <= rx_ovf_cnt   + 1'b1;
            if (tx_rd_unf  && pop_unf_cnt  != '1) pop_unf_cnt  <= pop_unf_cnt  + 1'b1;
            if (misroute   && misroute_cnt != '1) misroute_cnt <= misroute_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_bus_dev_fifo.sv
// Randomized and directed checks of bus_dev_fifo against a queue-based model.
module tb_bus_dev_fifo;
    localparam int PW = 32;
    localparam int DEPTH = 16;
    localparam int CW = 8;
    localparam logic [7:0] ID = 8'h03;
    localparam int SAT = 255;

    logic clk = 0, reset = 0;
    logic dev_wr = 0, pop = 0, push = 0, dev_rd = 0;
    logic [PW-1:0] dev_wr_data = '0, D_push = '0;
    logic dev_tx_full, pndng, dev_rx_valid;
    logic [PW-1:0] D_pop, dev_rx_data;
    logic [4:0] tx_cnt, rx_cnt;
    logic [CW-1:0] tx_ovf_cnt, rx_ovf_cnt, pop_unf_cnt, misroute_cnt;

    int n_chk = 0, n_fail = 0;

    logic [PW-1:0] txq[$], rxq[$];
    int m_tx_ovf = 0, m_rx_ovf = 0, m_unf = 0, m_mis = 0;

    bus_dev_fifo #(.pckg_sz(PW), .depth(DEPTH), .id(ID), .broadcast(8'hFF), .cnt_w(CW)) dut (
        .clk(clk), .reset(reset),
        .dev_wr(dev_wr), .dev_wr_data(dev_wr_data), .dev_tx_full(dev_tx_full),
        .pndng(pndng), .D_pop(D_pop), .pop(pop),
        .push(push), .D_push(D_push),
        .dev_rx_valid(dev_rx_valid), .dev_rx_data(dev_rx_data), .dev_rd(dev_rd),
        .tx_cnt(tx_cnt), .rx_cnt(rx_cnt),
        .tx_ovf_cnt(tx_ovf_cnt), .rx_ovf_cnt(rx_ovf_cnt),
        .pop_unf_cnt(pop_unf_cnt), .misroute_cnt(misroute_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [PW-1:0] tx_head, rx_head;
        tx_head = (txq.size() > 0) ? txq[0] : '0;
        rx_head = (rxq.size() > 0) ? rxq[0] : '0;
        chk({tag, ":pndng"},    64'(pndng),        64'(txq.size() > 0));
        chk({tag, ":tx_full"},  64'(dev_tx_full),  64'(txq.size() == DEPTH));
        chk({tag, ":D_pop"},    64'(D_pop),        64'(tx_head));
        chk({tag, ":tx_cnt"},   64'(tx_cnt),       64'(txq.size()));
        chk({tag, ":rx_valid"}, 64'(dev_rx_valid), 64'(rxq.size() > 0));
        chk({tag, ":rx_data"},  64'(dev_rx_data),  64'(rx_head));
        chk({tag, ":rx_cnt"},   64'(rx_cnt),       64'(rxq.size()));
        chk({tag, ":tx_ovf"},   64'(tx_ovf_cnt),   64'(m_tx_ovf));
        chk({tag, ":rx_ovf"},   64'(rx_ovf_cnt),   64'(m_rx_ovf));
        chk({tag, ":pop_unf"},  64'(pop_unf_cnt),  64'(m_unf));
        chk({tag, ":misroute"}, 64'(misroute_cnt), 64'(m_mis));
    endtask

    function automatic int sat_inc(input int v);
        return (v < SAT) ? v + 1 : SAT;
    endfunction

    // One clock of stimulus; model advanced from the queue rules, then checked.
    task automatic step(input logic w, input logic [PW-1:0] wd, input logic p,
                        input logic ps, input logic [PW-1:0] pd, input logic r,
                        input string tag);
        bit t_pop_ok, t_wr_ok, r_rd_ok, r_wr_ok;
        dev_wr = w; dev_wr_data = wd; pop = p;
        push = ps; D_push = pd; dev_rd = r;
        @(posedge clk);
        t_pop_ok = p && txq.size() > 0;
        t_wr_ok  = w && (txq.size() < DEPTH || t_pop_ok);
        if (p && txq.size() == 0) m_unf = sat_inc(m_unf);
        if (w && !t_wr_ok) m_tx_ovf = sat_inc(m_tx_ovf);
        r_rd_ok = r && rxq.size() > 0;
        r_wr_ok = ps && (rxq.size() < DEPTH || r_rd_ok);
        if (ps && !r_wr_ok) m_rx_ovf = sat_inc(m_rx_ovf);
        if (r_wr_ok && pd[31:24] != ID && pd[31:24] != 8'hFF) m_mis = sat_inc(m_mis);
        if (t_pop_ok) void'(txq.pop_front());
        if (t_wr_ok) txq.push_back(wd);
        if (r_rd_ok) void'(rxq.pop_front());
        if (r_wr_ok) rxq.push_back(pd);
        #1;
        dev_wr = 0; pop = 0; push = 0; dev_rd = 0;
        check_all(tag);
    endtask

    task automatic model_reset();
        txq.delete(); rxq.delete();
        m_tx_ovf = 0; m_rx_ovf = 0; m_unf = 0; m_mis = 0;
    endtask

    initial begin
        logic [PW-1:0] d;
        logic [7:0] dst;

        // Reset state
        #12;
        check_all("reset");
        #2 reset = 1;

        // 1: three writes, three pops
        step(1, 32'h01000011, 0, 0, '0, 0, "t1_w0");
        chk("t1_pndng_after_first", 64'(pndng), 64'd1);
        chk("t1_dpop_first", 64'(D_pop), 64'h01000011);
        step(1, 32'h01000022, 0, 0, '0, 0, "t1_w1");
        step(1, 32'h01000033, 0, 0, '0, 0, "t1_w2");
        chk("t1_tx_cnt3", 64'(tx_cnt), 64'd3);
        step(0, '0, 1, 0, '0, 0, "t1_p0");
        chk("t1_head22", 64'(D_pop), 64'h01000022);
        step(0, '0, 1, 0, '0, 0, "t1_p1");
        chk("t1_head33", 64'(D_pop), 64'h01000033);
        step(0, '0, 1, 0, '0, 0, "t1_p2");
        chk("t1_pndng_end", 64'(pndng), 64'd0);

        // 2: 18 writes into a 16-deep FIFO, then drain
        for (int i = 0; i < 18; i++) step(1, $urandom, 0, 0, '0, 0, "t2_w");
        chk("t2_full", 64'(dev_tx_full), 64'd1);
        chk("t2_ovf2", 64'(tx_ovf_cnt), 64'd2);
        for (int i = 0; i < 16; i++) step(0, '0, 1, 0, '0, 0, "t2_p");

        // 3: write+pop while full, then write+pop while empty
        for (int i = 0; i < 16; i++) step(1, 32'h0200_0000 | i, 0, 0, '0, 0, "t3_fill");
        step(1, 32'h0200_00AB, 1, 0, '0, 0, "t3_fullwp");
        chk("t3_cnt16", 64'(tx_cnt), 64'd16);
        chk("t3_ovf_same", 64'(tx_ovf_cnt), 64'd2);
        for (int i = 0; i < 15; i++) step(0, '0, 1, 0, '0, 0, "t3_drain");
        chk("t3_last", 64'(D_pop), 64'h020000AB);
        step(0, '0, 1, 0, '0, 0, "t3_drain_last");
        step(1, 32'h0200_00CD, 1, 0, '0, 0, "t3_emptywp");
        chk("t3_cnt1", 64'(tx_cnt), 64'd1);
        chk("t3_unf1", 64'(pop_unf_cnt), 64'd1);
        step(0, '0, 1, 0, '0, 0, "t3_clear");

        // 4: RX routing and overflow
        step(0, '0, 0, 1, 32'h03AAAAAA, 0, "t4_own");
        step(0, '0, 0, 1, 32'hFFBBBBBB, 0, "t4_bcast");
        step(0, '0, 0, 1, 32'h05CCCCCC, 0, "t4_other");
        chk("t4_rx_cnt3", 64'(rx_cnt), 64'd3);
        chk("t4_mis1", 64'(misroute_cnt), 64'd1);
        chk("t4_head", 64'(dev_rx_data), 64'h03AAAAAA);
        for (int i = 0; i < 15; i++) step(0, '0, 0, 1, {ID, 24'(i)}, 0, "t4_fill");
        step(0, '0, 0, 1, 32'h03DDDDDD, 1, "t4_fullpr");
        for (int i = 0; i < 20; i++) step(0, '0, 0, 0, '0, 1, "t4_drain");

        // 5: underflow saturation
        for (int i = 0; i < 300; i++) step(0, '0, 1, 0, '0, 0, "t5_unf");
        chk("t5_sat", 64'(pop_unf_cnt), 64'd255);

        // 6: async reset with packets queued, then wraparound
        for (int i = 0; i < 5; i++) step(1, $urandom, 0, 1, $urandom, 0, "t6_q");
        #2 reset = 0;
        #1;
        model_reset();
        chk("t6_pndng0", 64'(pndng), 64'd0);
        chk("t6_txcnt0", 64'(tx_cnt), 64'd0);
        chk("t6_unf0", 64'(pop_unf_cnt), 64'd0);
        check_all("t6_async");
        #2 reset = 1;
        step(1, 32'h0312_3456, 0, 0, '0, 0, "t6_w");
        chk("t6_readback", 64'(D_pop), 64'h03123456);
        for (int i = 0; i < 40; i++) step(1, $urandom, 1, 1, $urandom, 1, "t6_wrap");

        // Random mix
        for (int i = 0; i < 400; i++) begin
            d = $urandom;
            case ($urandom_range(2))
                0: dst = ID;
                1: dst = 8'hFF;
                default: dst = 8'($urandom);
            endcase
            step(1'($urandom_range(2) > 0), $urandom, 1'($urandom_range(1)),
                 1'($urandom_range(2) > 0), {dst, d[23:0]}, 1'($urandom_range(1)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
